// File: rtl/alu_rr_scheduler_if.sv
// Bundles the requester, response and ALU-side signals of the shared-ALU scheduler.
// The scheduler uses the slave modport; requesters, consumer and ALU together form the master.
interface alu_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int OP_W    = 3,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*OP_W-1:0]   req_sel;

    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_result;
    logic                      rsp_carry;
    logic                      rsp_zero;
    logic                      rsp_err;

    logic [DATA_W-1:0]         alu_a;
    logic [DATA_W-1:0]         alu_b;
    logic [OP_W-1:0]           alu_sel;
    logic [DATA_W-1:0]         alu_result;
    logic                      alu_carry_out;
    logic                      alu_zero;

    modport master (
        output req_valid, req_a, req_b, req_sel, rsp_ready,
               alu_result, alu_carry_out, alu_zero,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err,
               alu_a, alu_b, alu_sel
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, rsp_ready,
               alu_result, alu_carry_out, alu_zero,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_zero, rsp_err,
               alu_a, alu_b, alu_sel
    );
endinterface

// File: rtl/alu_rr_scheduler.sv
// Round-robin scheduler sharing one combinational ALU; IDLE(grant) -> EXEC(capture) -> RESP(handshake).
// Optional ALU_OP_CHECK_EN: opcodes above NOT bypass the ALU and return an error response.
module alu_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 4,
    parameter int OP_W    = 3,
    parameter int ID_W    = 2
) (
    input logic               clk,
    input logic               rst_n,
    alu_rr_scheduler_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] req_ready_q, req_ready_d;
    logic [DATA_W-1:0]  alu_a_q, alu_a_d;
    logic [DATA_W-1:0]  alu_b_q, alu_b_d;
    logic [OP_W-1:0]    alu_sel_q, alu_sel_d;
    logic               err_pend_q, err_pend_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0]  rsp_result_q, rsp_result_d;
    logic               rsp_carry_q, rsp_carry_d;
    logic               rsp_zero_q, rsp_zero_d;
    logic               rsp_err_q, rsp_err_d;

    logic               gnt_vld;
    logic [PTR_W-1:0]   gnt_idx;
    logic [DATA_W-1:0]  gnt_a;
    logic [DATA_W-1:0]  gnt_b;
    logic [OP_W-1:0]    gnt_sel;
    logic               op_ill;

    // Scan downwards so the requester closest to ptr (smallest offset) wins last.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(ptr_q) + k) % NUM_REQ]) begin
                gnt_vld = 1'b1;
                gnt_idx = PTR_W'((int'(ptr_q) + k) % NUM_REQ);
            end
        end
    end

    assign gnt_a   = bus.req_a[int'(gnt_idx)*DATA_W +: DATA_W];
    assign gnt_b   = bus.req_b[int'(gnt_idx)*DATA_W +: DATA_W];
    assign gnt_sel = bus.req_sel[int'(gnt_idx)*OP_W +: OP_W];

`ifdef ALU_OP_CHECK_EN
    assign op_ill = (gnt_sel > OP_W'(4));
`else
    assign op_ill = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        req_ready_d  = '0;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_sel_d    = alu_sel_q;
        err_pend_d   = err_pend_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_carry_d  = rsp_carry_q;
        rsp_zero_d   = rsp_zero_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    req_ready_d[gnt_idx] = 1'b1;
                    rsp_id_d             = ID_W'(gnt_idx);
                    ptr_d                = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
                    err_pend_d           = op_ill;
                    if (!op_ill) begin
                        alu_a_d   = gnt_a;
                        alu_b_d   = gnt_b;
                        alu_sel_d = gnt_sel;
                    end
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (err_pend_q) begin
                    rsp_result_d = '0;
                    rsp_carry_d  = 1'b0;
                    rsp_zero_d   = 1'b1;
                    rsp_err_d    = 1'b1;
                end else begin
                    rsp_result_d = bus.alu_result;
                    rsp_carry_d  = bus.alu_carry_out;
                    rsp_zero_d   = bus.alu_zero;
                    rsp_err_d    = 1'b0;
                end
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            req_ready_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_sel_q    <= '0;
            err_pend_q   <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
            rsp_carry_q  <= 1'b0;
            rsp_zero_q   <= 1'b0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            req_ready_q  <= req_ready_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_sel_q    <= alu_sel_d;
            err_pend_q   <= err_pend_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_carry_q  <= rsp_carry_d;
            rsp_zero_q   <= rsp_zero_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;
    assign bus.rsp_zero   = rsp_zero_q;
    assign bus.rsp_err    = rsp_err_q;
endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: behavioural ALU, round-robin grant model and response scoreboard.
module tb_alu_rr_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_rr_scheduler_if #(.NUM_REQ(4), .DATA_W(4), .OP_W(3), .ID_W(2)) bus ();

    alu_rr_scheduler #(.NUM_REQ(4), .DATA_W(4), .OP_W(3), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [3:0] res;
        logic       c;
        logic       z;
        logic       e;
    } exp_t;

    exp_t     sb[$];
    int       gnt_log[$];
    int       n_chk = 0;
    int       n_pass = 0;
    int       m_ptr = 0;
    logic [2:0] m_sel = 3'b000;
    bit       hold = 1'b0;

    // returns {carry, result, zero}
    function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        logic [4:0] r;
        case (s)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {1'b0, a} - {1'b0, b};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, ~a};
            default: r = {1'b0, a ^ b};
        endcase
        return {r, r[3:0] == 4'b0000};
    endfunction

    always_comb begin
        {bus.alu_carry_out, bus.alu_result, bus.alu_zero} = alu_f(bus.alu_a, bus.alu_b, bus.alu_sel);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            chk("rsp_unexpected", 1, 0);
        end else begin
            e = sb.pop_front();
            chk("rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, e);
        end
    endtask

    task automatic grant_check(input logic [3:0] v, input logic [15:0] a, input logic [15:0] b,
                               input logic [11:0] s);
        int   g;
        bit   found;
        bit   ill;
        logic [5:0] r;
        exp_t e;
        found = 1'b0;
        g = 0;
        for (int k = 0; k < 4; k++) begin
            if (!found && v[(m_ptr + k) % 4]) begin
                found = 1'b1;
                g = (m_ptr + k) % 4;
            end
        end
        if (!found) begin
            chk("grant_spurious", bus.req_ready, 0);
            return;
        end
        chk("grant", bus.req_ready, 32'(4'b0001 << g));
        m_ptr = (g + 1) % 4;
        gnt_log.push_back(g);
`ifdef ALU_OP_CHECK_EN
        ill = (s[g*3 +: 3] > 3'b100);
`else
        ill = 1'b0;
`endif
        r = alu_f(a[g*4 +: 4], b[g*4 +: 4], s[g*3 +: 3]);
        e.id = 2'(g);
        if (ill) begin
            e.res = 4'b0000; e.c = 1'b0; e.z = 1'b1; e.e = 1'b1;
        end else begin
            e.res = r[4:1]; e.c = r[5]; e.z = r[0]; e.e = 1'b0;
            m_sel = s[g*3 +: 3];
        end
        sb.push_back(e);
        chk("alu_sel", bus.alu_sel, m_sel);
        if (!hold) bus.req_valid[g] = 1'b0;
    endtask

    task automatic step();
        logic [3:0]  v;
        logic [15:0] a;
        logic [15:0] b;
        logic [11:0] s;
        logic        r;
        v = bus.req_valid; a = bus.req_a; b = bus.req_b; s = bus.req_sel; r = rst_n;
        if (r && bus.rsp_valid && bus.rsp_ready) pop_check();
        @(posedge clk);
        #1;
        if (!r) begin
            m_ptr = 0;
            m_sel = 3'b000;
            sb.delete();
        end else if (bus.req_ready != 4'b0000) begin
            grant_check(v, a, b, s);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
        bus.req_a[i*4 +: 4]   = a;
        bus.req_b[i*4 +: 4]   = b;
        bus.req_sel[i*3 +: 3] = s;
        bus.req_valid[i]      = 1'b1;
    endtask

    task automatic do_reset();
        bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        gnt_log.delete();
    endtask

    task automatic wait_rsp(input string tag);
        for (int i = 0; i < 20; i++) begin
            if (bus.rsp_valid) return;
            step();
        end
        chk(tag, 0, 1);
    endtask

    task automatic drain();
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (bus.req_valid == 4'b0000 && sb.size() == 0 && !bus.rsp_valid && bus.req_ready == 4'b0000)
                return;
            step();
        end
        chk("drain_timeout", 0, 1);
    endtask

    initial begin
        int   order[5];
        logic [2:0] sel_before;
        bit   saw;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.req_sel = '0;
        bus.rsp_ready = 1'b1;

        do_reset();
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 0);
        chk("rst_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);

        // single ADD, latency and field values
        set_req(0, 4'b0101, 4'b0011, 3'b000);
        step();
        chk("t1_ready", bus.req_ready, 4'b0001);
        chk("t1_exec_valid", bus.rsp_valid, 0);
        step();
        chk("t1_valid", bus.rsp_valid, 1);
        chk("t1_fields", {bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero}, {2'd0, 4'b1000, 1'b0, 1'b0});
        step();
        chk("t1_done", bus.rsp_valid, 0);
        drain();

        // all four requesters held valid
        do_reset();
        hold = 1'b1;
        set_req(0, 4'b1001, 4'b1000, 3'b000);
        set_req(1, 4'b0011, 4'b0100, 3'b011);
        set_req(2, 4'b0110, 4'b0011, 3'b010);
        set_req(3, 4'b1111, 4'b0000, 3'b100);
        for (int i = 0; i < 40 && gnt_log.size() < 5; i++) step();
        hold = 1'b0;
        bus.req_valid = '0;
        order = '{0, 1, 2, 3, 0};
        chk("t2_count", gnt_log.size() >= 5, 1);
        for (int i = 0; i < 5; i++)
            if (i < gnt_log.size()) chk("t2_order", gnt_log[i], order[i]);
        drain();

        // consumer stall with another request pending
        do_reset();
        bus.rsp_ready = 1'b0;
        set_req(0, 4'b1100, 4'b0111, 3'b001);
        wait_rsp("t3_timeout");
        set_req(1, 4'b0001, 4'b0001, 3'b000);
        for (int i = 0; i < 5; i++) begin
            if (sb.size() > 0)
                chk("t3_stall_rsp", {bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, sb[0]);
            chk("t3_stall_valid", bus.rsp_valid, 1);
            chk("t3_stall_ready", bus.req_ready, 0);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("t3_release", bus.rsp_valid, 0);
        drain();
        chk("t3_next_grant", gnt_log.size() == 2 && gnt_log[1] == 1, 1);

        // SUB to zero, then pointer at 3 picks requester 3 before 1, then wraps
        do_reset();
        set_req(2, 4'b0101, 4'b0101, 3'b001);
        wait_rsp("t4_timeout");
        chk("t4_sub", {bus.rsp_id, bus.rsp_result, bus.rsp_zero}, {2'd2, 4'b0000, 1'b1});
        drain();
        gnt_log.delete();
        set_req(1, 4'b0001, 4'b0010, 3'b000);
        set_req(3, 4'b1111, 4'b1010, 3'b010);
        drain();
        chk("t4_count", gnt_log.size(), 2);
        if (gnt_log.size() == 2) begin
            chk("t4_first", gnt_log[0], 3);
            chk("t4_second", gnt_log[1], 1);
        end

        // illegal opcode
        sel_before = m_sel;
        set_req(1, 4'b1010, 4'b0101, 3'b111);
        wait_rsp("t5_timeout");
`ifdef ALU_OP_CHECK_EN
        chk("t5_alu_sel", bus.alu_sel, sel_before);
        chk("t5_rsp", {bus.rsp_err, bus.rsp_result, bus.rsp_carry, bus.rsp_zero}, {1'b1, 4'b0000, 1'b0, 1'b1});
`else
        chk("t5_alu_sel", bus.alu_sel, 3'b111);
        chk("t5_rsp", {bus.rsp_err, bus.rsp_result, bus.rsp_zero}, {1'b0, 4'b1111, 1'b0});
`endif
        drain();

        // reset while in EXEC drops the operation
        set_req(2, 4'b0111, 4'b0001, 3'b000);
        step();
        chk("t6_granted", bus.req_ready, 4'b0100);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_ready", bus.req_ready, 0);
        chk("t6_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 0);
        chk("t6_alu", {bus.alu_a, bus.alu_b, bus.alu_sel}, 0);
        saw = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.rsp_valid) saw = 1'b1;
            step();
        end
        chk("t6_no_rsp", saw, 0);
        gnt_log.delete();
        set_req(1, 4'b0010, 4'b0010, 3'b011);
        set_req(0, 4'b0011, 4'b0001, 3'b001);
        drain();
        chk("t6_ptr0", gnt_log.size() > 0 && gnt_log[0] == 0, 1);

        // consumer ready while idle has no effect
        bus.rsp_ready = 1'b1;
        step();
        step();
        chk("idle_ready", {bus.rsp_valid, bus.req_ready}, 0);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
